fp_addsub_export_pipe: RTL and testbench

- Parametrised, pipelined result-export stage for the floating-point add/sub unit.
- Classifies both operands and picks the final result: the datapath result, a passed-through operand, a signed infinity, a signed zero, or canonical NaN.
- Generalised over exponent/mantissa width and add/sub mode; produces exception flags.
- Sits after the mantissa adder/normaliser; valid/ready on both sides, latency 2 cycles.

---
 rtl/fp_addsub_export_pipe.sv | 160 ++++++++++++++++
 tb/tb_fp_addsub_export_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_export_pipe.sv
// Two-stage result-export pipeline for the FP add/sub unit: classifies operands, picks the final result and flags.
// Optional macro FP_EXPORT_DENORM_FLUSH_EN: subnormal operands and subnormal datapath results are flushed to signed zero.
module fp_addsub_export_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic                     in_sub,
    input  logic [EXP_W+MAN_W:0]     in_temp,
    input  logic [1:0]               in_toobig,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic [2:0]               out_flags
);
    localparam int W = 1 + EXP_W + MAN_W;

    localparam logic [3:0] CLS_FIN  = 4'b0001;
    localparam logic [3:0] CLS_ZERO = 4'b0010;
    localparam logic [3:0] CLS_INF  = 4'b0100;
    localparam logic [3:0] CLS_NAN  = 4'b1000;

    localparam logic [W-2:0] INF_BODY = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [W-1:0] QNAN     = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b1}}};

    function automatic logic [3:0] classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        logic [3:0] c;
        c = CLS_FIN;
        if (e == {EXP_W{1'b1}}) begin
            c = (m == {MAN_W{1'b0}}) ? CLS_INF : CLS_NAN;
        end else if (e == {EXP_W{1'b0}}) begin
`ifdef FP_EXPORT_DENORM_FLUSH_EN
            c = CLS_ZERO;
`else
            c = (m == {MAN_W{1'b0}}) ? CLS_ZERO : CLS_FIN;
`endif
        end else begin
            c = CLS_FIN;
        end
        return c;
    endfunction

    logic           r_s1_valid;
    logic [W-1:0]   r_s1_a;
    logic [W-1:0]   r_s1_b;
    logic [W-1:0]   r_s1_temp;
    logic [1:0]     r_s1_toobig;
    logic [3:0]     r_s1_cls_a;
    logic [3:0]     r_s1_cls_b;
    logic           r_out_valid;
    logic [W-1:0]   r_out_result;
    logic [2:0]     r_out_flags;

    logic           w_s1_advance;
    logic           w_in_fire;
    logic [W-1:0]   w_sel_result;
    logic [2:0]     w_sel_flags;
    logic           w_a_sign;
    logic           w_b_sign;

    assign w_s1_advance = r_s1_valid && (!r_out_valid || out_ready);
    assign in_ready     = !r_s1_valid || w_s1_advance;
    assign w_in_fire    = in_valid && in_ready;
    assign out_valid    = r_out_valid;
    assign out_result   = r_out_result;
    assign out_flags    = r_out_flags;
    assign w_a_sign     = r_s1_a[W-1];
    assign w_b_sign     = r_s1_b[W-1];

    // Stage 1: capture operands (B with its effective sign) and their classes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= {W{1'b0}};
            r_s1_b      <= {W{1'b0}};
            r_s1_temp   <= {W{1'b0}};
            r_s1_toobig <= 2'b00;
            r_s1_cls_a  <= 4'b0000;
            r_s1_cls_b  <= 4'b0000;
        end else if (w_in_fire) begin
            r_s1_valid  <= 1'b1;
            r_s1_a      <= in_a;
            r_s1_b      <= {in_b[W-1] ^ in_sub, in_b[W-2:0]};
            r_s1_temp   <= in_temp;
            r_s1_toobig <= in_toobig;
            r_s1_cls_a  <= classify(in_a[W-2:MAN_W], in_a[MAN_W-1:0]);
            r_s1_cls_b  <= classify(in_b[W-2:MAN_W], in_b[MAN_W-1:0]);
        end else if (w_s1_advance) begin
            r_s1_valid  <= 1'b0;
        end else begin
            r_s1_valid  <= r_s1_valid;
        end
    end

    // Result selection, specials first so they override the bypass
    always_comb begin
        w_sel_result = r_s1_temp;
        w_sel_flags  = 3'b000;
        if (r_s1_cls_a[3] || r_s1_cls_b[3]) begin
            w_sel_result = QNAN;
            w_sel_flags  = 3'b001;
        end else if (r_s1_cls_a[2] && r_s1_cls_b[2]) begin
            if (w_a_sign != w_b_sign) begin
                w_sel_result = QNAN;
                w_sel_flags  = 3'b100;
            end else begin
                w_sel_result = {w_a_sign, INF_BODY};
            end
        end else if (r_s1_cls_a[2]) begin
            w_sel_result = {w_a_sign, INF_BODY};
        end else if (r_s1_cls_b[2]) begin
            w_sel_result = {w_b_sign, INF_BODY};
        end else if (r_s1_cls_a[1] && r_s1_cls_b[1]) begin
            w_sel_result = {w_a_sign & w_b_sign, {(W-1){1'b0}}};
        end else if (r_s1_cls_a[1]) begin
            w_sel_result = r_s1_b;
        end else if (r_s1_cls_b[1]) begin
            w_sel_result = r_s1_a;
        end else if (r_s1_toobig[0]) begin
            w_sel_result = r_s1_toobig[1] ? r_s1_b : r_s1_a;
        end else begin
`ifdef FP_EXPORT_DENORM_FLUSH_EN
            if (r_s1_temp[W-2:MAN_W] == {EXP_W{1'b0}}) begin
                w_sel_result = {r_s1_temp[W-1], {(W-1){1'b0}}};
            end else begin
                w_sel_result = r_s1_temp;
            end
`else
            w_sel_result = r_s1_temp;
`endif
            if (r_s1_temp[W-2:0] == INF_BODY) begin
                w_sel_flags = 3'b010;
            end else begin
                w_sel_flags = 3'b000;
            end
        end
    end

    // Stage 2: output register, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_result <= {W{1'b0}};
            r_out_flags  <= 3'b000;
        end else if (w_s1_advance) begin
            r_out_valid  <= 1'b1;
            r_out_result <= w_sel_result;
            r_out_flags  <= w_sel_flags;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end else begin
            r_out_valid  <= r_out_valid;
        end
    end
endmodule

// File: tb/tb_fp_addsub_export_pipe.sv
// Self-checking bench for fp_addsub_export_pipe: table-driven vectors through a scoreboard queue plus
// backpressure and mid-stream reset sequences.
module tb_fp_addsub_export_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = 32'h0;
    logic [31:0] in_b = 32'h0;
    logic        in_sub = 1'b0;
    logic [31:0] in_temp = 32'h0;
    logic [1:0]  in_toobig = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    int checks = 0;
    int errors = 0;
    logic [34:0] cur_exp = 35'h0;
    logic [34:0] sb_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] temp;
        logic [1:0]  tb;
        logic [31:0] res;
        logic [2:0]  flags;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    fp_addsub_export_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_temp(in_temp), .in_toobig(in_toobig),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: push on input handshake, pop and compare on output handshake
    always @(negedge clk) begin
        logic [34:0] e;
        if (rst_n) begin
            if (in_valid && in_ready) sb_q.push_back(cur_exp);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none", out_result);
                end else begin
                    e = sb_q.pop_front();
                    check("result", out_result, e[31:0]);
                    check("flags", {29'h0, out_flags}, {29'h0, e[34:32]});
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] temp, input logic [1:0] tb,
                        input logic [31:0] res, input logic [2:0] flags);
        int  n;
        logic acc;
        in_a = a; in_b = b; in_sub = sub; in_temp = temp; in_toobig = tb;
        cur_exp = {flags, res};
        in_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no in_ready expected accept");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] dn_res0;
        logic [31:0] dn_res1;
`ifdef FP_EXPORT_DENORM_FLUSH_EN
        dn_res0 = 32'h3F800000;
        dn_res1 = 32'h80000000;
`else
        dn_res0 = 32'h12345678;
        dn_res1 = 32'h80000005;
`endif
        vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 2'b00, 32'h40400000, 3'b000};
        vecs[1]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h12345678, 2'b00, 32'h7FFFFFFF, 3'b100};
        vecs[2]  = '{32'h7F800000, 32'h7F800000, 1'b0, 32'h12345678, 2'b00, 32'h7F800000, 3'b000};
        vecs[3]  = '{32'h80000000, 32'h00000000, 1'b1, 32'h12345678, 2'b00, 32'h80000000, 3'b000};
        vecs[4]  = '{32'h80000000, 32'h00000000, 1'b0, 32'h12345678, 2'b00, 32'h00000000, 3'b000};
        vecs[5]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h12345678, 2'b01, 32'h7FFFFFFF, 3'b001};
        vecs[6]  = '{32'hFF800000, 32'h3F800000, 1'b0, 32'h12345678, 2'b00, 32'hFF800000, 3'b000};
        vecs[7]  = '{32'h3F800000, 32'h7F800000, 1'b1, 32'h12345678, 2'b00, 32'hFF800000, 3'b000};
        vecs[8]  = '{32'h00000000, 32'h40000000, 1'b1, 32'h12345678, 2'b00, 32'hC0000000, 3'b000};
        vecs[9]  = '{32'h40000000, 32'h80000000, 1'b0, 32'h12345678, 2'b00, 32'h40000000, 3'b000};
        vecs[10] = '{32'h3F800000, 32'h4B000000, 1'b1, 32'h12345678, 2'b11, 32'hCB000000, 3'b000};
        vecs[11] = '{32'h3F800000, 32'h4B000000, 1'b1, 32'h12345678, 2'b01, 32'h3F800000, 3'b000};
        vecs[12] = '{32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 2'b00, 32'h7F800000, 3'b010};
        vecs[13] = '{32'hFF000000, 32'h7F000000, 1'b1, 32'hFF800000, 2'b00, 32'hFF800000, 3'b010};
        vecs[14] = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h12345678, 2'b00, 32'h7FFFFFFF, 3'b100};
        vecs[15] = '{32'h3F800000, 32'hFFC00000, 1'b0, 32'h12345678, 2'b11, 32'h7FFFFFFF, 3'b001};
        vecs[16] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h12345678, 2'b00, dn_res0,      3'b000};
        vecs[17] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h80000005, 2'b00, dn_res1,      3'b000};
        vecs[18] = '{32'h80000000, 32'h00000000, 1'b1, 32'h12345678, 2'b01, 32'h80000000, 3'b000};
        vecs[19] = '{32'hFF800000, 32'h7F800000, 1'b1, 32'h12345678, 2'b00, 32'hFF800000, 3'b000};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_out_flags", {29'h0, out_flags}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", {31'h0, in_ready}, 32'h1);
        check("idle_out_valid", {31'h0, out_valid}, 32'h0);

        for (int i = 0; i < NV; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].temp, vecs[i].tb, vecs[i].res, vecs[i].flags);
        end
        drain();

        // Backpressure: stall the output with both stages full, then release
        out_ready = 1'b0;
        fork
            begin
                send(32'h3F800000, 32'h40000000, 1'b0, 32'h11111111, 2'b00, 32'h11111111, 3'b000);
                send(32'h3F800000, 32'h40000000, 1'b0, 32'h22222222, 2'b00, 32'h22222222, 3'b000);
                send(32'h3F800000, 32'h40000000, 1'b0, 32'h33333333, 2'b00, 32'h33333333, 3'b000);
            end
            begin
                repeat (4) @(negedge clk);
                check("bp_in_ready", {31'h0, in_ready}, 32'h0);
                check("bp_out_valid", {31'h0, out_valid}, 32'h1);
                check("bp_first_word", out_result, 32'h11111111);
                held = out_result;
                repeat (2) begin
                    @(negedge clk);
                    check("bp_stable", out_result, held);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-stream drops in-flight words
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h44444444, 2'b00, 32'h44444444, 3'b000);
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h55555555, 2'b00, 32'h55555555, 3'b000);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_out_result", out_result, 32'h0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("postrst_no_output", {31'h0, out_valid}, 32'h0);
        end
        send(32'h00000000, 32'h3F800000, 1'b1, 32'h12345678, 2'b00, 32'hBF800000, 3'b000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
